// File: rtl/ub_activation_feeder_pkg.sv
// Shared widths, state encoding and helpers for the unified-buffer activation feeder.
// The unified buffer and the feeder import this so word layout and widths agree.
package ub_activation_feeder_pkg;

  localparam int DATA_W  = 16;
  localparam int WORD_W  = 32;
  localparam int ADDR_W  = 4;
  localparam int MAX_VEC = 4;
  localparam int NV_W    = $clog2(MAX_VEC + 1);
  localparam int CNT_W   = $clog2(4 + 2 * MAX_VEC + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_LOADW = 3'd3;
  localparam logic [2:0] ST_FEED  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic logic [NV_W-1:0] clamp_vec(input logic [NV_W-1:0] n);
    return (n > NV_W'(MAX_VEC)) ? NV_W'(MAX_VEC) : n;
  endfunction

endpackage

// File: rtl/ub_activation_feeder_if.sv
// Unified-buffer read port plus the weight/activation bus into the mmu.
// valid is a pure strobe: the mmu has no ready, so every valid cycle is consumed as-is.
interface ub_activation_feeder_if;
  import ub_activation_feeder_pkg::*;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic [DATA_W-1:0] weight1;
  logic [DATA_W-1:0] weight2;
  logic [DATA_W-1:0] weight3;
  logic [DATA_W-1:0] weight4;
  logic              load_weight;
  logic [DATA_W-1:0] a_in1;
  logic [DATA_W-1:0] a_in2;
  logic              valid;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output weight1, weight2, weight3, weight4, load_weight,
    output a_in1, a_in2, valid
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  weight1, weight2, weight3, weight4, load_weight,
    input  a_in1, a_in2, valid
  );

endinterface

// File: rtl/ub_activation_feeder_prefetch_buf.sv
// Prefetch register file for activation words, written in fetch order.
// Two read ports give row0 of vector t and row1 of vector t-1 for the systolic skew.
module feeder_prefetch_buf
  import ub_activation_feeder_pkg::*;
#(
  parameter int DEPTH = 2 * MAX_VEC,
  parameter int W     = DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [W-1:0]    wr_data,
  input  logic [NV_W-1:0] vec_idx,
  output logic [W-1:0]    row0,
  output logic [W-1:0]    row1
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [NV_W:0]    idx0;
  logic [NV_W:0]    idx1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Contents are don't-care after reset; only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign idx0 = {vec_idx, 1'b0};
  assign idx1 = idx0 - 1'b1;

  assign row0 = (idx0 < (NV_W+1)'(DEPTH)) ? mem[idx0[PTR_W-1:0]] : '0;
  assign row1 = ((vec_idx != '0) && (idx1 < (NV_W+1)'(DEPTH))) ? mem[idx1[PTR_W-1:0]] : '0;

endmodule

// File: rtl/ub_activation_feeder.sv
// Reads a 2x2 weight tile and N activation vectors from the unified buffer,
// pulses load_weight, then streams skewed activations into the mmu.
module ub_activation_feeder
  import ub_activation_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [NV_W-1:0]   num_vec,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state,
  ub_activation_feeder_if.master bus
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] a_base;
  logic [NV_W-1:0]   n_lat;
  logic [CNT_W-1:0]  fetch_cnt;
  logic [CNT_W-1:0]  fetch_last;
  logic [CNT_W-1:0]  cap_idx;
  logic              rd_en_q;
  logic [NV_W-1:0]   feed_t;
  logic [DATA_W-1:0] wreg [4];
  logic              accept;
  logic              buf_wr;
  logic [DATA_W-1:0] row0;
  logic [DATA_W-1:0] row1;

  assign accept     = (state == ST_IDLE) && start;
  assign fetch_last = CNT_W'(3) + CNT_W'({n_lat, 1'b0});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      w_base    <= '0;
      a_base    <= '0;
      n_lat     <= '0;
      fetch_cnt <= '0;
      feed_t    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            w_base    <= w_addr;
            a_base    <= a_addr;
            n_lat     <= clamp_vec(num_vec);
            fetch_cnt <= '0;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          fetch_cnt <= fetch_cnt + 1'b1;
          if (fetch_cnt == fetch_last) state <= ST_WAIT;
        end
        ST_WAIT: state <= ST_LOADW;
        ST_LOADW: begin
          feed_t <= '0;
          state  <= (n_lat == '0) ? ST_DONE : ST_FEED;
        end
        ST_FEED: begin
          if (feed_t == n_lat) state <= ST_DONE;
          else                 feed_t <= feed_t + 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data lands one cycle after each strobe; first four words are weights.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en_q <= 1'b0;
      cap_idx <= '0;
      for (int i = 0; i < 4; i++) wreg[i] <= '0;
    end else begin
      rd_en_q <= (state == ST_FETCH);
      if (accept) begin
        cap_idx <= '0;
      end else if (rd_en_q) begin
        cap_idx <= cap_idx + 1'b1;
        if (cap_idx < CNT_W'(4)) wreg[cap_idx[1:0]] <= bus.rd_data[DATA_W-1:0];
      end
    end
  end

  assign buf_wr = rd_en_q && (cap_idx >= CNT_W'(4));

  feeder_prefetch_buf u_buf (
    .clk     (clk),
    .rst     (reset),
    .clr     (accept),
    .wr_en   (buf_wr),
    .wr_data (bus.rd_data[DATA_W-1:0]),
    .vec_idx (feed_t),
    .row0    (row0),
    .row1    (row1)
  );

  always_comb begin
    bus.rd_addr = '0;
    if (state == ST_FETCH) begin
      if (fetch_cnt < CNT_W'(4)) bus.rd_addr = w_base + ADDR_W'(fetch_cnt);
      else                       bus.rd_addr = a_base + ADDR_W'(fetch_cnt - CNT_W'(4));
    end
  end

  assign bus.rd_en       = (state == ST_FETCH);
  assign bus.weight1     = wreg[0];
  assign bus.weight2     = wreg[1];
  assign bus.weight3     = wreg[2];
  assign bus.weight4     = wreg[3];
  assign bus.load_weight = (state == ST_LOADW);
  assign bus.valid       = (state == ST_FEED);
  assign bus.a_in1       = ((state == ST_FEED) && (feed_t != n_lat)) ? row0 : '0;
  assign bus.a_in2       = (state == ST_FEED) ? row1 : '0;
  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_DONE);
  assign dbg_state       = state;

endmodule

// File: tb/tb_ub_activation_feeder.sv
// Bench for ub_activation_feeder: table-driven jobs, hand sequences for restart and
// mid-job reset, and random jobs checked against a queue-based reference model.
module tb_ub_activation_feeder;
  import ub_activation_feeder_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] a_addr;
  logic [NV_W-1:0]   num_vec;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;

  ub_activation_feeder_if bus ();

  ub_activation_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .w_addr    (w_addr),
    .a_addr    (a_addr),
    .num_vec   (num_vec),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  // Unified buffer model: one-cycle read latency, garbage when not read.
  logic [WORD_W-1:0] mem [16];
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    else           bus.rd_data <= WORD_W'($urandom);
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model results.
  logic [ADDR_W-1:0]   exp_addr_q [$];
  logic [2*DATA_W-1:0] exp_feed_q [$];
  logic [4*DATA_W-1:0] exp_w;

  function automatic logic [DATA_W-1:0] word_at(input int a);
    logic [WORD_W-1:0] w;
    w = mem[a % 16];
    return w[DATA_W-1:0];
  endfunction

  task automatic build_model(input int wa, input int aa, input int nv, output int n);
    logic [DATA_W-1:0] r0, r1;
    n = (nv > MAX_VEC) ? MAX_VEC : nv;
    exp_addr_q.delete();
    exp_feed_q.delete();
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(ADDR_W'((wa + i) % 16));
    for (int i = 0; i < 2 * n; i++) exp_addr_q.push_back(ADDR_W'((aa + i) % 16));
    exp_w = {word_at(wa), word_at(wa + 1), word_at(wa + 2), word_at(wa + 3)};
    if (n > 0) begin
      for (int t = 0; t <= n; t++) begin
        r0 = (t < n) ? word_at(aa + 2 * t) : '0;
        r1 = (t > 0) ? word_at(aa + 2 * t - 1) : '0;
        exp_feed_q.push_back({r0, r1});
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) mem[i] = WORD_W'($urandom);
  endtask

  task automatic fill_scn1();
    fill_random();
    for (int i = 0; i < 8; i++) mem[i] = {16'($urandom), 16'(i + 1)};
  endtask

  // Runs one job from a negedge; all observation happens on negedges.
  task automatic run_job(input string tag, input int wa, input int aa, input int nv,
                         input int exp_reads, input int exp_valid, input int exp_busy,
                         input bit restart);
    int n;
    int first_rd = 0, last_rd = 0, lw_cnt = 0, lw_cyc = 0, first_v = 0;
    int busy_cnt = 0, done_cyc = 0, stray = 0;
    logic [ADDR_W-1:0]   rd_q [$];
    logic [2*DATA_W-1:0] feed_q [$];
    logic [4*DATA_W-1:0] got_w = '0;
    build_model(wa, aa, nv, n);
    w_addr  = ADDR_W'(wa);
    a_addr  = ADDR_W'(aa);
    num_vec = NV_W'(nv);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    w_addr  = ADDR_W'($urandom);
    a_addr  = ADDR_W'($urandom);
    num_vec = NV_W'($urandom);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (bus.rd_en) begin
        rd_q.push_back(bus.rd_addr);
        if (first_rd == 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (bus.load_weight) begin
        lw_cnt++;
        lw_cyc = cyc;
        got_w  = {bus.weight1, bus.weight2, bus.weight3, bus.weight4};
      end
      if (bus.valid) begin
        feed_q.push_back({bus.a_in1, bus.a_in2});
        if (first_v == 0) first_v = cyc;
      end else if (bus.a_in1 != '0 || bus.a_in2 != '0) begin
        stray++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (restart && (cyc == 2 || (bus.valid && feed_q.size() == 1))) begin
        start   = 1'b1;
        w_addr  = ADDR_W'($urandom);
        a_addr  = ADDR_W'($urandom);
        num_vec = NV_W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check($sformatf("%s_done_cycle", tag), 64'(done_cyc), 64'(exp_busy));
    check($sformatf("%s_busy_cycles", tag), 64'(busy_cnt), 64'(exp_busy));
    check($sformatf("%s_read_count", tag), 64'(rd_q.size()), 64'(exp_reads));
    for (int i = 0; i < exp_addr_q.size() && i < rd_q.size(); i++)
      check($sformatf("%s_rd_addr%0d", tag, i), 64'(rd_q[i]), 64'(exp_addr_q[i]));
    check($sformatf("%s_first_read", tag), 64'(first_rd), 64'd1);
    check($sformatf("%s_last_read", tag), 64'(last_rd), 64'(exp_reads));
    check($sformatf("%s_lw_pulses", tag), 64'(lw_cnt), 64'd1);
    check($sformatf("%s_lw_cycle", tag), 64'(lw_cyc), 64'(exp_reads + 2));
    check($sformatf("%s_weights", tag), got_w, exp_w);
    check($sformatf("%s_valid_count", tag), 64'(feed_q.size()), 64'(exp_valid));
    for (int i = 0; i < exp_feed_q.size() && i < feed_q.size(); i++)
      check($sformatf("%s_feed%0d", tag, i), 64'(feed_q[i]), 64'(exp_feed_q[i]));
    if (exp_valid > 0)
      check($sformatf("%s_first_valid", tag), 64'(first_v), 64'(exp_reads + 3));
    check($sformatf("%s_stray_act", tag), 64'(stray), 64'd0);
    @(negedge clk);
    check($sformatf("%s_idle_after", tag), {61'd0, busy, done, bus.valid}, 64'd0);
    check($sformatf("%s_state_idle", tag), 64'(dbg_state), 64'(ST_IDLE));
    check($sformatf("%s_w_held", tag),
          {bus.weight1, bus.weight2, bus.weight3, bus.weight4}, exp_w);
  endtask

  typedef struct {
    int wa;
    int aa;
    int nv;
    bit scn1;
    int reads;
    int nvalid;
    int nbusy;
  } vec_t;

  initial begin
    vec_t tbl [6];
    int vcount;
    int bad_cnt;
    tbl[0] = '{0,  4,  2, 1'b1, 8,  3, 14};
    tbl[1] = '{0,  4,  0, 1'b1, 4,  0, 7};
    tbl[2] = '{14, 2,  1, 1'b0, 6,  2, 11};
    tbl[3] = '{3,  8,  7, 1'b0, 12, 5, 20};
    tbl[4] = '{5,  9,  3, 1'b0, 10, 4, 17};
    tbl[5] = '{12, 15, 4, 1'b0, 12, 5, 20};

    reset = 1'b1; start = 1'b0; w_addr = '0; a_addr = '0; num_vec = '0;
    fill_random();
    #1;
    check("reset_bus", {bus.rd_en, bus.rd_addr, bus.load_weight, bus.valid, bus.a_in1, bus.a_in2},
          '0);
    check("reset_weights", {bus.weight1, bus.weight2, bus.weight3, bus.weight4}, '0);
    check("reset_status", {61'd0, busy, done, 1'b0}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].scn1) fill_scn1();
      else             fill_random();
      if (tbl[i].wa == 14) mem[14] = 32'h0001_0007;
      run_job($sformatf("tbl%0d", i), tbl[i].wa, tbl[i].aa, tbl[i].nv,
              tbl[i].reads, tbl[i].nvalid, tbl[i].nbusy, 1'b0);
    end

    fill_scn1();
    run_job("restart", 0, 4, 2, 8, 3, 14, 1'b1);

    // Async reset in the second FEED cycle, between clock edges.
    fill_scn1();
    w_addr = 4'd0; a_addr = 4'd4; num_vec = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.valid) vcount++;
      if (vcount == 2) break;
      @(negedge clk);
    end
    check("rst_reach_feed1", 64'(vcount), 64'd2);
    #2 reset = 1'b1;
    #1;
    check("rst_async_stream", {31'd0, bus.valid, bus.a_in1, bus.a_in2}, 64'd0);
    check("rst_async_status", {61'd0, busy, done, bus.load_weight}, 64'd0);
    check("rst_async_weights", {bus.weight1, bus.weight2, bus.weight3, bus.weight4}, '0);
    @(negedge clk);
    reset = 1'b0;
    bad_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (done || busy || bus.valid) bad_cnt++;
      @(negedge clk);
    end
    check("rst_no_done", 64'(bad_cnt), 64'd0);
    run_job("post_rst", 0, 4, 2, 8, 3, 14, 1'b0);

    for (int k = 0; k < 8; k++) begin
      int wa, aa, nv, n, reads, nvalid, nbusy;
      fill_random();
      wa = $urandom_range(0, 15);
      aa = $urandom_range(0, 15);
      nv = $urandom_range(0, 7);
      n      = (nv > MAX_VEC) ? MAX_VEC : nv;
      reads  = 4 + 2 * n;
      nvalid = (n > 0) ? n + 1 : 0;
      nbusy  = (n > 0) ? reads + 1 + 1 + (n + 1) + 1 : reads + 3;
      run_job($sformatf("rnd%0d", k), wa, aa, nv, reads, nvalid, nbusy, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
